// File: rtl/adc_calib_calc_if.sv
// Bundles the sample, calibration-coefficient and result signals of adc_calib_calc.
// The slave modport is the calculator side; the master modport is the driving side (register block and ADC front end).
interface adc_calib_calc_if #(
  parameter int ADC_WIDTH = 18
);
  logic [7*ADC_WIDTH-1:0] i_adc_data;
  logic [6:0]             i_adc_valid;
  logic [7*32-1:0]        i_factor;
  logic [7*32-1:0]        i_offset;
  logic                   i_ovr_clr;
  logic [7*32-1:0]        o_result;
  logic [6:0]             o_result_valid;
  logic [6:0]             o_sat;
  logic [6:0]             o_ovr;
  logic                   o_busy;

  modport slave (
    input  i_adc_data, i_adc_valid, i_factor, i_offset, i_ovr_clr,
    output o_result, o_result_valid, o_sat, o_ovr, o_busy
  );

  modport master (
    output i_adc_data, i_adc_valid, i_factor, i_offset, i_ovr_clr,
    input  o_result, o_result_valid, o_sat, o_ovr, o_busy
  );
endinterface

// File: rtl/adc_calib_calc.sv
// 7-channel ADC calibration, result = sample * factor + offset in Q16.16, one shared round-robin datapath; ADC_CALC_SAT_EN enables saturation.
// Latency 4 edges from strobe to result pulse, one channel per 4 cycles; no backpressure: re-strobing a pending channel overwrites the sample and sets o_ovr.
module adc_calib_calc #(
  parameter int ADC_WIDTH = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  adc_calib_calc_if.slave   bus
);
  localparam int NCH = 7;
  localparam int PW  = ADC_WIDTH + 32;
  localparam int SW  = ADC_WIDTH + 33;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]                  state;
  logic [NCH-1:0]              pending;
  logic [2:0]                  last_gnt;
  logic [2:0]                  cur_ch;
  logic signed [ADC_WIDTH-1:0] samp_q [NCH];
  logic signed [ADC_WIDTH-1:0] op_samp;
  logic signed [31:0]          op_fac;
  logic signed [31:0]          op_off;
  logic signed [PW-1:0]        prod;
  logic [31:0]                 res_q;
  logic                        sat_q;

  logic                        gnt_vld;
  logic [2:0]                  gnt_ch;
  logic                        take;
  logic signed [SW-1:0]        sum;
  logic [31:0]                 res_nxt;
  logic                        sat_nxt;

  always_comb begin : rr_arb
    int idx;
    gnt_vld = 1'b0;
    gnt_ch  = 3'd0;
    idx     = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last_gnt) + k) % NCH;
      if (!gnt_vld && pending[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = 3'(idx);
      end
    end
  end

  assign take = (state == S_IDLE) && gnt_vld;

  assign sum = {prod[PW-1], prod} + {{(SW-32){op_off[31]}}, op_off};

`ifdef ADC_CALC_SAT_EN
  logic ovf_hi;
  logic ovf_lo;
  assign ovf_hi = !sum[SW-1] && (|sum[SW-2:31]);
  assign ovf_lo =  sum[SW-1] && !(&sum[SW-2:31]);
  assign res_nxt = ovf_hi ? 32'h7FFF_FFFF : (ovf_lo ? 32'h8000_0000 : sum[31:0]);
  assign sat_nxt = ovf_hi | ovf_lo;
`else
  logic sum_hi_unused;
  assign sum_hi_unused = ^sum[SW-1:32];
  assign res_nxt = sum[31:0];
  assign sat_nxt = 1'b0;
`endif

  // A strobe landing on the same edge its channel is granted is not an overrun:
  // the older sample is consumed by the datapath, the new one becomes pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending   <= '0;
      bus.o_ovr <= '0;
      for (int ch = 0; ch < NCH; ch++) samp_q[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (take && (gnt_ch == 3'(ch))) pending[ch] <= 1'b0;
        if (bus.i_adc_valid[ch]) begin
          samp_q[ch]  <= $signed(bus.i_adc_data[ch*ADC_WIDTH +: ADC_WIDTH]);
          pending[ch] <= 1'b1;
        end
        if (bus.i_adc_valid[ch] && pending[ch] && !(take && (gnt_ch == 3'(ch))))
          bus.o_ovr[ch] <= 1'b1;
        else if (bus.i_ovr_clr)
          bus.o_ovr[ch] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= S_IDLE;
      last_gnt           <= 3'd6;
      cur_ch             <= 3'd0;
      op_samp            <= '0;
      op_fac             <= '0;
      op_off             <= '0;
      prod               <= '0;
      res_q              <= '0;
      sat_q              <= 1'b0;
      bus.o_result       <= '0;
      bus.o_result_valid <= '0;
      bus.o_sat          <= '0;
    end else begin
      bus.o_result_valid <= '0;
      bus.o_sat          <= '0;
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            cur_ch   <= gnt_ch;
            last_gnt <= gnt_ch;
            op_samp  <= samp_q[gnt_ch];
            op_fac   <= $signed(bus.i_factor[gnt_ch*32 +: 32]);
            op_off   <= $signed(bus.i_offset[gnt_ch*32 +: 32]);
            state    <= S_MUL;
          end
        end
        S_MUL: begin
          prod  <= op_samp * op_fac;
          state <= S_ADD;
        end
        S_ADD: begin
          res_q <= res_nxt;
          sat_q <= sat_nxt;
          state <= S_OUT;
        end
        default: begin
          bus.o_result[cur_ch*32 +: 32] <= res_q;
          bus.o_result_valid[cur_ch]    <= 1'b1;
          bus.o_sat[cur_ch]             <= sat_q;
          state                         <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy = (state != S_IDLE) || (|pending);

endmodule

// File: doc/adc_calib_calc.md
ADC_CALIB_CALC -- requirements
Module: adc_calib_calc

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 18, signed raw ADC sample width; channel count fixed at 7 (c, v, dc_c, dc_v, phase_r, phase_s, phase_t = ch0..ch6).
REQ-002 SHALL have ports: i_clk  in  1  sole clock; rising edge. Single clock domain.
REQ-003 SHALL have ports: i_rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: i_adc_data  in  7*ADC_WIDTH  signed raw samples, ch n at [n*ADC_WIDTH +: ADC_WIDTH].
REQ-005 SHALL have ports: i_adc_valid  in  7  per-channel one-cycle sample strobe.
REQ-006 SHALL have ports: i_factor  in  7*32  signed Q16.16 gain per channel, from register block slv_reg[0..6].
REQ-007 SHALL have ports: i_offset  in  7*32  signed Q16.16 offset per channel, from slv_reg[10..16].
REQ-008 SHALL have ports: i_ovr_clr  in  1  clears o_ovr.
REQ-009 SHALL have ports: o_result  out  7*32  signed Q16.16 calibrated value per channel, held until next update.
REQ-010 SHALL have ports: o_result_valid  out  7  one-cycle pulse when o_result[ch] updates.
REQ-011 SHALL have ports: o_sat  out  7  one-cycle pulse with o_result_valid when that result saturated.
REQ-012 SHALL have ports: o_ovr  out  7  sticky overrun flag per channel.
REQ-013 SHALL have ports: o_busy  out  1  high when FSM not in IDLE or any channel pending.

Function
REQ-014 SHALL capture i_adc_data[ch] and set pending[ch] on the edge sampling i_adc_valid[ch]=1.
REQ-015 SHALL, if i_adc_valid[ch] arrives while pending[ch]=1, overwrite the captured sample with the new one and set o_ovr[ch]; set has priority over i_ovr_clr in the same cycle.
REQ-016 SHALL run one shared datapath with FSM IDLE -> MUL -> ADD -> OUT -> IDLE, one cycle per state.
REQ-017 SHALL in IDLE grant round-robin: search starts at last-granted+1 modulo 7; last-granted = 6 after reset; no pending -> stay IDLE.
REQ-018 SHALL on grant clear pending[ch] and snapshot sample, i_factor[ch], i_offset[ch]; later changes to inputs do not affect the in-flight computation.
REQ-019 SHALL in MUL register prod = sample * factor, full signed ADC_WIDTH+32 bits.
REQ-020 SHALL in ADD register sum = prod + sign-extended offset (ADC_WIDTH+33 bits), then reduce to 32 bits per REQ-027/028.
REQ-021 SHALL in OUT write o_result[ch], pulse o_result_valid[ch] and o_sat[ch] (if saturated) for exactly one cycle.
REQ-022 SHALL yield latency of 4 edges from the edge sampling i_adc_valid to the edge asserting o_result_valid when idle; throughput one channel per 4 cycles.
REQ-023 SHALL treat a valid on the channel currently in flight as a new pending sample (no overrun).

Reset
REQ-024 SHALL on i_rst=1 force FSM to IDLE, pending=0, last-granted=6, captured samples=0, o_result=0, o_result_valid=0, o_sat=0, o_ovr=0, o_busy=0.
REQ-025 SHALL on reset mid-computation abort without any o_result_valid pulse; o_result stays 0.
REQ-026 SHALL ignore i_adc_valid in a cycle where i_rst=1.

Configuration
REQ-027 SHALL, with ADC_CALC_SAT_EN defined, saturate sum to [0x8000_0000, 0x7FFF_FFFF] and flag o_sat.
REQ-028 SHALL, without ADC_CALC_SAT_EN, take sum[31:0] (two's-complement wrap) and tie o_sat to 0.

Verification
REQ-029 SHALL cover: ch0 adc=1000, factor=0x0001_0000, offset=0x0000_8000 -> o_result[0]=0x03E8_8000, valid pulse 4 edges after strobe, o_sat=0.
REQ-030 SHALL cover: ch3 adc=131071, factor=0x7FFF_FFFF, offset=0 -> 0x7FFF_FFFF with o_sat[3]=1 (SAT_EN); adc=-131072 -> 0x8000_0000; without macro -> low 32 bits of product.
REQ-031 SHALL cover: i_adc_valid=7'h7F in one cycle -> o_result_valid pulses ch0..ch6 in order at 4, 8, ... 28 edges after strobe.
REQ-032 SHALL cover: ch2 strobed twice (adc=5, then 9) while ch0/ch1 in flight -> o_ovr[2]=1, single ch2 result computed from 9; i_ovr_clr -> o_ovr[2]=0.
REQ-033 SHALL cover: i_factor[1] changed during MUL of ch1 -> result uses the old factor; i_rst asserted in ADD state -> no valid pulse, all outputs 0 next cycle.
